// File: rtl/pc_tracker_pkg.sv
// rtl/pc_tracker_pkg.sv - stage index constants and state-width helper for the PC stage tracker
package pc_tracker_pkg;

  localparam int STG_NONE = 0;
  localparam int STG_ID   = 1;
  localparam int STG_EX   = 2;
  localparam int STG_MEM  = 3;
  localparam int STG_WB   = 4;

  function automatic int stateWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pc_deepest_match.sv
// rtl/pc_deepest_match.sv - combinational highest-set-bit index of a stage hit vector, 0 when empty
module pc_deepest_match
  import pc_tracker_pkg::*;
#(
  parameter int STAGES = 4,
  localparam int SW = stateWidth(STAGES)
) (
  input  logic [STAGES-1:0] hit,
  output logic [SW-1:0]     idx
);

  // Ascending scan: a later (deeper) hit overwrites a shallower one.
  always_comb begin
    idx = SW'(STG_NONE);
    for (int k = 0; k < STAGES; k++) begin
      if (hit[k]) idx = SW'(k + 1);
    end
  end

endmodule

// File: rtl/pc_stage_tracker.sv
// rtl/pc_stage_tracker.sv - per-stage valid-tagged PC copies with registered deepest-match lookup
module pc_stage_tracker
  import pc_tracker_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int STAGES = 4,
  parameter int CNT_W  = 4,
  localparam int SW    = stateWidth(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              flush,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              pc_in_valid,
  input  logic [PC_W-1:0]   query_pc,
  output logic [SW-1:0]     state,
  output logic [STAGES-1:0] hit_mask,
  output logic [CNT_W-1:0]  repeat_cnt
);

  logic [PC_W-1:0]   pcStage [1:STAGES];
  logic [STAGES:1]   vStage;
  logic [STAGES-1:0] hitNow;
  logic [SW-1:0]     deepNow;

  // Lookup runs on pre-edge storage so a freshly loaded PC is seen one cycle later.
  always_comb begin
    hitNow = '0;
    for (int k = 1; k <= STAGES; k++) begin
      hitNow[k-1] = vStage[k] && (pcStage[k] == query_pc);
    end
  end

  pc_deepest_match #(.STAGES(STAGES)) uDeepest (
    .hit (hitNow),
    .idx (deepNow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vStage     <= '0;
      state      <= '0;
      hit_mask   <= '0;
      repeat_cnt <= '0;
      for (int k = 1; k <= STAGES; k++) pcStage[k] <= '0;
    end else begin
      hit_mask <= hitNow;
      state    <= deepNow;
      if (deepNow != '0) begin
        repeat_cnt <= (repeat_cnt == {CNT_W{1'b1}}) ? repeat_cnt : repeat_cnt + 1'b1;
      end else begin
        repeat_cnt <= '0;
      end

      if (flush && advance) begin
        pcStage[1] <= pc_in;
        vStage[1]  <= pc_in_valid;
        for (int k = 2; k <= STAGES; k++) vStage[k] <= 1'b0;
      end else if (flush) begin
        vStage <= '0;
      end else if (advance) begin
        // Invalid stages still shift their PC; every compare is gated by the valid bit.
        for (int k = STAGES; k >= 2; k--) begin
          pcStage[k] <= pcStage[k-1];
          vStage[k]  <= vStage[k-1];
        end
        pcStage[1] <= pc_in;
        vStage[1]  <= pc_in_valid;
      end
    end
  end

endmodule

// File: tb/tb_pc_stage_tracker.sv
// tb/tb_pc_stage_tracker.sv - randomized and directed self-checking bench for pc_stage_tracker
module tb_pc_stage_tracker;

  localparam int NST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       advance = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] pc_in = '0;
  logic       pc_in_valid = 1'b0;
  logic [7:0] query_pc = '0;
  logic [2:0] state;
  logic [3:0] hit_mask;
  logic [3:0] repeat_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] pc;
    bit         v;
  } entry_t;

  entry_t hist[$];
  int     expState = 0;
  int     expMask = 0;
  int     expCnt = 0;

  pc_stage_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .flush       (flush),
    .pc_in       (pc_in),
    .pc_in_valid (pc_in_valid),
    .query_pc    (query_pc),
    .state       (state),
    .hit_mask    (hit_mask),
    .repeat_cnt  (repeat_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: hist[0] is the youngest instruction (ID), hist[NST-1] the oldest (WB).
  task automatic modelEdge();
    int st;
    int mk;
    st = 0;
    mk = 0;
    if (rst) begin
      hist.delete();
      expState = 0;
      expMask = 0;
      expCnt = 0;
      return;
    end
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i].v && hist[i].pc == query_pc) begin
        mk |= (1 << i);
        st = i + 1;
      end
    end
    expState = st;
    expMask = mk;
    expCnt = (st != 0) ? ((expCnt < 15) ? expCnt + 1 : 15) : 0;
    if (flush) begin
      for (int i = 0; i < hist.size(); i++) hist[i].v = 0;
    end
    if (advance) begin
      entry_t e;
      e.pc = pc_in;
      e.v = pc_in_valid;
      hist.push_front(e);
      if (hist.size() > NST) void'(hist.pop_back());
    end
  endtask

  task automatic step(input bit r, input bit adv, input bit fl,
                      input logic [7:0] pcv, input bit vld, input logic [7:0] q);
    rst = r;
    advance = adv;
    flush = fl;
    pc_in = pcv;
    pc_in_valid = vld;
    query_pc = q;
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    checkVal("state", int'(state), expState);
    checkVal("hit_mask", int'(hit_mask), expMask);
    checkVal("repeat_cnt", int'(repeat_cnt), expCnt);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 8'h00, 0, 8'h00);
    checkVal("reset_state_lit", int'(state), 0);
    checkVal("reset_cnt_lit", int'(repeat_cnt), 0);

    // 0x10 reaches WB after four advances
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h10 + i), 1, 8'hFF);
    step(0, 0, 0, 8'h00, 0, 8'h10);
    checkVal("wb_state_lit", int'(state), 4);
    checkVal("wb_mask_lit", int'(hit_mask), 4'b1000);

    // duplicates in EX and WB
    step(0, 1, 0, 8'h20, 1, 8'hFF);
    step(0, 1, 0, 8'h21, 1, 8'hFF);
    step(0, 1, 0, 8'h20, 1, 8'hFF);
    step(0, 1, 0, 8'h22, 1, 8'hFF);
    step(0, 0, 0, 8'h00, 0, 8'h20);
    checkVal("dup_state_lit", int'(state), 4);
    checkVal("dup_mask_lit", int'(hit_mask), 4'b1010);

    // bubble never matches
    step(0, 1, 0, 8'h30, 0, 8'h30);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'(8'h31 + i), 1, 8'h30);
      checkVal("bubble_state_lit", int'(state), 0);
    end

    // stall with 0x40 held in ID
    step(0, 1, 0, 8'h40, 1, 8'hFF);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 8'h00, 0, 8'h40);
      checkVal("stall_state_lit", int'(state), 1);
      checkVal("stall_cnt_lit", int'(repeat_cnt), i);
    end

    // flush with advance
    step(0, 1, 1, 8'h50, 1, 8'h50);
    step(0, 0, 0, 8'h00, 0, 8'h50);
    checkVal("flush_state_lit", int'(state), 1);
    step(0, 0, 0, 8'h00, 0, 8'h40);
    checkVal("flush_old_lit", int'(state), 0);
    step(0, 0, 0, 8'h00, 0, 8'h34);
    checkVal("flush_old2_lit", int'(state), 0);

    // saturation
    for (int i = 0; i < 20; i++) step(0, 0, 0, 8'h00, 0, 8'h50);
    checkVal("sat_cnt_lit", int'(repeat_cnt), 15);

    // reset mid-run
    step(1, 1, 0, 8'h50, 1, 8'h50);
    checkVal("rst_state_lit", int'(state), 0);
    checkVal("rst_mask_lit", int'(hit_mask), 0);
    checkVal("rst_cnt_lit", int'(repeat_cnt), 0);

    // randomized traffic with a small PC space so hits are frequent
    for (int n = 0; n < 400; n++) begin
      bit r;
      bit a;
      bit f;
      bit vl;
      logic [7:0] p;
      logic [7:0] q;
      r  = ($urandom_range(0, 99) < 2);
      a  = ($urandom_range(0, 99) < 60);
      f  = ($urandom_range(0, 99) < 6);
      vl = ($urandom_range(0, 99) < 80);
      p  = 8'($urandom_range(0, 7));
      if (hist.size() > 0 && $urandom_range(0, 1) == 1)
        q = hist[$urandom_range(0, hist.size() - 1)].pc;
      else
        q = 8'($urandom_range(0, 7));
      step(r, a, f, p, vl, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_stage_tracker.md
# pc_stage_tracker

Parametrised successor to the pipeline PC state counter. The block holds its own valid-tagged copy of the PC in each pipeline stage (ID … WB), advancing with the pipeline and honouring stalls and flushes. Each cycle it reports the deepest valid stage whose PC equals a query PC, plus a per-stage hit mask and a saturating count of consecutive hit cycles. It sits beside the fetch/decode control and feeds loop- and hazard-detection logic.

## Interface
- `PC_W`, default 8: PC width in bits.
- `STAGES`, default 4: tracked stages; stage 1 = ID, stage `STAGES` = WB.
- `CNT_W`, default 4: width of `repeat_cnt`.
- `SW`, derived, `$clog2(STAGES+1)`: width of `state`. Not overridable.

Clocking and reset: one clock, `clk`; reset `rst` is synchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `advance`  in  1  pipeline moves one stage this cycle; low means stall (hold).
- `flush`  in  1  invalidate tracked stages.
- `pc_in`  in  `PC_W`  PC entering stage 1 on `advance`.
- `pc_in_valid`  in  1  `pc_in` is a real instruction; low inserts a bubble.
- `query_pc`  in  `PC_W`  PC to look up (the next-PC).
- `state`  out  `SW`  deepest matching stage index; 0 = no match.
- `hit_mask`  out  `STAGES`  bit k-1 set when stage k is valid and matches.
- `repeat_cnt`  out  `CNT_W`  consecutive cycles with `state` != 0, saturating.

## Operation
- Storage is `pc[k]` and `v[k]` for k = 1..`STAGES`.
- Lookup is combinational over the current (pre-edge) storage: `hit[k] = v[k] && (pc[k] == query_pc)`.
  - Deepest set hit wins: highest k.
  - Registered into `hit_mask`/`state` at the edge.
  - Default encoding: 4=WB, 3=MEM, 2=EX, 1=ID, 0=none.
- Stage update, in priority order:
  - `rst`: all `v` = 0, all `pc` = 0.
  - `flush` && `advance`: `v[2..STAGES]` = 0; stage 1 loads `pc_in`/`pc_in_valid`.
  - `flush` alone: all `v` = 0.
  - `advance`: stage 1 loads `pc_in`/`pc_in_valid`; `pc[k]`/`v[k]` take `pc[k-1]`/`v[k-1]`; the WB entry is discarded.
  - Otherwise: hold.
- `pc` of an invalid stage is don't-care but still shifts. Comparisons are always gated by `v`.
- `repeat_cnt` update:
  - Next `state` != 0: increment, saturating at 2^`CNT_W`-1.
  - Next `state` == 0: clear to 0.
  - `rst`: 0.
- `STAGES` = 1 is legal: `SW` = 1.

## Timing
- Reset values: `state` = 0, `hit_mask` = 0, `repeat_cnt` = 0, all `v` = 0.
- Lookup latency is 1 cycle. Outputs at edge N reflect `query_pc` and storage before edge N.
- A PC loaded on edge N is visible to the lookup in cycle N+1, so it can first appear on outputs after edge N+1.
- Flush or advance on edge N does not alter the outputs registered on edge N. The effect shows on outputs from edge N+1.
- Stall holds storage only. The lookup still runs every cycle, so outputs track `query_pc` changes during a stall.
- Reset asserted mid-operation:
  - Clears storage and outputs on that edge.
  - First non-zero `state` possible 2 edges after the first `advance` with `pc_in_valid`.
- Duplicate PCs in several stages: all matching bits are set in `hit_mask`; `state` reports the deepest.

## Structure
- Package `pc_tracker_pkg` holds:
  - stage index constants `STG_NONE` = 0, `STG_ID` = 1, `STG_EX` = 2, `STG_MEM` = 3, `STG_WB` = 4, for the default depth;
  - a function returning `$clog2(n+1)`.
- Sub-module `pc_deepest_match`:
  - parametrised on `STAGES`;
  - purely combinational;
  - `hit` vector in, highest-set index out, 0 when empty.
- Top level holds the stage shift register, the output registers and the counter.

## Test plan
- Reset, then advance PCs 0x10, 0x11, 0x12, 0x13 (all valid), with `query_pc` = 0x10 on the following cycle → `state` = 4, `hit_mask` = 4'b1000.
- Stages hold 0x20 (EX) and 0x20 (WB), `query_pc` = 0x20 → `state` = 4, `hit_mask` = 4'b1010.
- Bubble: advance 0x30 with `pc_in_valid` = 0, `query_pc` = 0x30 → `state` = 0 in every later cycle.
- Stall for 5 cycles with 0x40 in ID, `query_pc` = 0x40 → `state` = 1 throughout; `repeat_cnt` counts 1..5.
- `flush` with `advance` and `pc_in` = 0x50 (valid), `query_pc` = 0x50 → after 2 edges `state` = 1; all older PCs no longer match.
- Saturation and reset:
  - `CNT_W` = 4, hit held for 20 cycles → `repeat_cnt` sticks at 15.
  - `rst` pulse mid-run → next edge: `state`, `hit_mask` and `repeat_cnt` all 0.
